// File: rtl/scope_pkg.sv
// Shared types and constants for the oscilloscope capture sequencer.
package scope_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned IDX_W    = 10;
    localparam int unsigned ADDR_W   = IDX_W + 1;
    localparam int unsigned DECIM_W  = 4;
    localparam int unsigned MODE_W   = 2;
    localparam int unsigned STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 3'd0,
        PRETRIG  = 3'd1,
        ARMED    = 3'd2,
        POSTTRIG = 3'd3,
        HOLD     = 3'd4
    } state_e;

    typedef enum logic [MODE_W-1:0] {
        MODE_AUTO       = 2'd0,
        MODE_NORMAL     = 2'd1,
        MODE_SINGLE     = 2'd2,
        MODE_NORMAL_ALT = 2'd3
    } mode_e;

    typedef enum logic {
        SLOPE_RISE = 1'b0,
        SLOPE_FALL = 1'b1
    } slope_e;

    // One buffer write beat: bank select, column index and sample.
    typedef struct packed {
        logic                bank;
        logic [IDX_W-1:0]    idx;
        logic [SAMPLE_W-1:0] data;
    } wr_beat_t;

    // States in which ticked samples are written to the buffer.
    function automatic logic is_capture_state(input state_e s);
        return (s == PRETRIG) || (s == ARMED) || (s == POSTTRIG);
    endfunction

endpackage

// File: rtl/scope_trig_detect.sv
// Level-crossing trigger detector: remembers the previous ticked sample and
// flags a crossing of the threshold in the selected direction.
module scope_trig_detect
    import scope_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_tick,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic [SAMPLE_W-1:0] i_level,
    input  logic                i_slope,
    output logic                o_hit_c
);

    logic signed [SAMPLE_W-1:0] prev_q;
    logic signed [SAMPLE_W-1:0] cur_s;
    logic signed [SAMPLE_W-1:0] lvl_s;

    assign cur_s = i_sample;
    assign lvl_s = i_level;

    // Previous sample only advances on decimated ticks.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_q <= '0;
        end else if (i_tick) begin
            prev_q <= cur_s;
        end
    end

    // Signed crossing compare against the live threshold.
    always_comb begin
        o_hit_c = 1'b0;
        if (i_slope == SLOPE_FALL) begin
            o_hit_c = (prev_q > lvl_s) && (cur_s <= lvl_s);
        end else begin
            o_hit_c = (prev_q < lvl_s) && (cur_s >= lvl_s);
        end
    end

endmodule

// File: rtl/scope_capture_ctrl.sv
// Trigger/capture sequencer for the scope sample buffer: decimates samples,
// detects the trigger, schedules double-banked writes and publishes a finished
// bank to the display at vertical blank.
module scope_capture_ctrl
    import scope_pkg::*;
#(
    parameter int unsigned DEPTH        = 560,
    parameter int unsigned PRE_TRIG     = 280,
    parameter int unsigned AUTO_TIMEOUT = 4096
) (
    input  logic                i_clk_25mhz,
    input  logic                i_rst,
    input  logic                i_sample_valid,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic [MODE_W-1:0]   i_mode,
    input  logic                i_slope,
    input  logic [SAMPLE_W-1:0] i_trig_level,
    input  logic [DECIM_W-1:0]  i_decim,
    input  logic                i_arm,
    input  logic                i_vblank,
    output logic                o_wr_en,
    output logic [ADDR_W-1:0]   o_wr_addr,
    output logic [SAMPLE_W-1:0] o_wr_data,
    output logic                o_rd_bank,
    output logic [IDX_W-1:0]    o_rd_base,
    output logic                o_frame_ready,
    output logic                o_triggered,
    output logic [STATE_W-1:0]  o_state
);

    localparam int unsigned POST_TICKS = DEPTH - PRE_TRIG - 1;
    localparam int unsigned TO_W       = $clog2(AUTO_TIMEOUT + 1);

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PRE_TRIG - 1);
    localparam logic [IDX_W-1:0] POST_LAST = IDX_W'(POST_TICKS - 1);
    localparam logic [IDX_W-1:0] PRE_OFS   = IDX_W'(PRE_TRIG);
    localparam logic [IDX_W-1:0] WRAP_OFS  = IDX_W'(DEPTH - PRE_TRIG);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(AUTO_TIMEOUT - 1);

    state_e               state_q, state_d, eff_state;
    logic [DECIM_W-1:0]   decim_q, decim_d;
    logic [IDX_W-1:0]     idx_q, idx_d, eff_idx;
    logic                 bank_q, bank_d, eff_bank;
    logic [IDX_W-1:0]     cnt_q, cnt_d, cnt_base;
    logic [TO_W-1:0]      to_q, to_d;
    logic [IDX_W-1:0]     trig_idx_q, trig_idx_d;
    logic [IDX_W-1:0]     base_q, base_d;
    logic                 hold_entry_q, hold_entry_d;
    logic                 wr_en_q, wr_en_d;
    wr_beat_t             wr_q, wr_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]     rd_base_q, rd_base_d;
    logic                 frame_ready_q, frame_ready_d;
    logic                 triggered_q, triggered_d;

    logic                 tick_c;
    logic                 hit_c;
    logic                 leave_c;
    logic                 is_single_c;
    logic                 is_auto_c;

    assign tick_c      = i_sample_valid && (decim_q == i_decim);
    assign is_single_c = (i_mode == MODE_SINGLE);
    assign is_auto_c   = (i_mode == MODE_AUTO);

    scope_trig_detect u_trig_detect (
        .i_clk    (i_clk_25mhz),
        .i_rst    (i_rst),
        .i_tick   (tick_c),
        .i_sample (i_sample),
        .i_level  (i_trig_level),
        .i_slope  (i_slope),
        .o_hit_c  (hit_c)
    );

    // Sequencer: IDLE/HOLD exits resolve first so a coincident tick lands in the new state.
    always_comb begin
        state_d       = state_q;
        decim_d       = decim_q;
        idx_d         = idx_q;
        bank_d        = bank_q;
        cnt_d         = cnt_q;
        to_d          = to_q;
        trig_idx_d    = trig_idx_q;
        base_d        = base_q;
        hold_entry_d  = 1'b0;
        wr_en_d       = 1'b0;
        wr_d          = wr_q;
        rd_bank_d     = rd_bank_q;
        rd_base_d     = rd_base_q;
        frame_ready_d = 1'b0;
        triggered_d   = triggered_q;
        eff_state     = state_q;
        eff_idx       = idx_q;
        eff_bank      = bank_q;
        leave_c       = 1'b0;

        if (i_sample_valid) begin
            decim_d = tick_c ? '0 : decim_q + DECIM_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!is_single_c || i_arm) begin
                    leave_c   = 1'b1;
                    eff_state = PRETRIG;
                end
            end
            HOLD: begin
                if (i_vblank && !hold_entry_q) begin
                    leave_c       = 1'b1;
                    eff_state     = is_single_c ? IDLE : PRETRIG;
                    eff_idx       = '0;
                    eff_bank      = ~bank_q;
                    rd_bank_d     = bank_q;
                    rd_base_d     = base_q;
                    frame_ready_d = 1'b1;
                    triggered_d   = 1'b0;
                end
            end
            default: ;
        endcase

        cnt_base = leave_c ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (leave_c) begin
            decim_d = '0;
        end
        state_d = eff_state;
        idx_d   = eff_idx;
        bank_d  = eff_bank;

        if (tick_c && is_capture_state(eff_state)) begin
            wr_en_d   = 1'b1;
            wr_d.bank = eff_bank;
            wr_d.idx  = eff_idx;
            wr_d.data = i_sample;
            idx_d     = (eff_idx == IDX_LAST) ? '0 : eff_idx + IDX_W'(1);

            case (eff_state)
                PRETRIG: begin
                    if (cnt_base == PRE_LAST) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                        to_d    = '0;
                    end else begin
                        cnt_d = cnt_base + IDX_W'(1);
                    end
                end
                ARMED: begin
                    if (hit_c || (is_auto_c && (to_q == TO_LAST))) begin
                        state_d     = POSTTRIG;
                        cnt_d       = '0;
                        trig_idx_d  = eff_idx;
                        triggered_d = 1'b1;
                    end else if (to_q != TO_LAST) begin
                        to_d = to_q + TO_W'(1);
                    end
                end
                POSTTRIG: begin
                    if (cnt_base == POST_LAST) begin
                        state_d      = HOLD;
                        cnt_d        = '0;
                        hold_entry_d = 1'b1;
                        base_d       = (trig_idx_q >= PRE_OFS) ? (trig_idx_q - PRE_OFS)
                                                              : (trig_idx_q + WRAP_OFS);
                    end else begin
                        cnt_d = cnt_base + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk_25mhz) begin
        if (i_rst) begin
            state_q       <= IDLE;
            decim_q       <= '0;
            idx_q         <= '0;
            bank_q        <= 1'b0;
            cnt_q         <= '0;
            to_q          <= '0;
            trig_idx_q    <= '0;
            base_q        <= '0;
            hold_entry_q  <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_q          <= '0;
            rd_bank_q     <= 1'b0;
            rd_base_q     <= '0;
            frame_ready_q <= 1'b0;
            triggered_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            decim_q       <= decim_d;
            idx_q         <= idx_d;
            bank_q        <= bank_d;
            cnt_q         <= cnt_d;
            to_q          <= to_d;
            trig_idx_q    <= trig_idx_d;
            base_q        <= base_d;
            hold_entry_q  <= hold_entry_d;
            wr_en_q       <= wr_en_d;
            wr_q          <= wr_d;
            rd_bank_q     <= rd_bank_d;
            rd_base_q     <= rd_base_d;
            frame_ready_q <= frame_ready_d;
            triggered_q   <= triggered_d;
        end
    end

    assign o_wr_en       = wr_en_q;
    assign o_wr_addr     = {wr_q.bank, wr_q.idx};
    assign o_wr_data     = wr_q.data;
    assign o_rd_bank     = rd_bank_q;
    assign o_rd_base     = rd_base_q;
    assign o_frame_ready = frame_ready_q;
    assign o_triggered   = triggered_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Scoreboard bench for scope_capture_ctrl: directed capture scenarios push
// expected buffer writes and frame publications; a monitor pops and compares.
module tb_scope_capture_ctrl;

    logic               clk = 1'b0;
    logic               i_rst;
    logic               i_sample_valid;
    logic signed [15:0] i_sample;
    logic [1:0]         i_mode;
    logic               i_slope;
    logic signed [15:0] i_trig_level;
    logic [3:0]         i_decim;
    logic               i_arm;
    logic               i_vblank;
    logic               o_wr_en;
    logic [10:0]        o_wr_addr;
    logic [15:0]        o_wr_data;
    logic               o_rd_bank;
    logic [9:0]         o_rd_base;
    logic               o_frame_ready;
    logic               o_triggered;
    logic [2:0]         o_state;

    always #20 clk = ~clk;

    scope_capture_ctrl dut (
        .i_clk_25mhz    (clk),
        .i_rst          (i_rst),
        .i_sample_valid (i_sample_valid),
        .i_sample       (i_sample),
        .i_mode         (i_mode),
        .i_slope        (i_slope),
        .i_trig_level   (i_trig_level),
        .i_decim        (i_decim),
        .i_arm          (i_arm),
        .i_vblank       (i_vblank),
        .o_wr_en        (o_wr_en),
        .o_wr_addr      (o_wr_addr),
        .o_wr_data      (o_wr_data),
        .o_rd_bank      (o_rd_bank),
        .o_rd_base      (o_rd_base),
        .o_frame_ready  (o_frame_ready),
        .o_triggered    (o_triggered),
        .o_state        (o_state)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_wr   = 0;

    logic [26:0]        exp_wr_q[$];
    logic [10:0]        exp_fr_q[$];
    logic               exp_bank;
    int                 exp_idx;
    logic signed [15:0] shadow [0:1][0:559];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every write strobe and frame pulse must match the next expectation.
    initial begin
        logic [26:0] ew;
        logic [10:0] ef;
        forever begin
            @(negedge clk);
            if (o_wr_en) begin
                n_wr++;
                if (o_wr_addr[9:0] < 10'd560) shadow[o_wr_addr[10]][o_wr_addr[9:0]] = o_wr_data;
                if (exp_wr_q.size() == 0) begin
                    chk("unexpected_wr", int'(o_wr_addr), -1);
                end else begin
                    ew = exp_wr_q.pop_front();
                    chk("wr_addr", int'(o_wr_addr), int'(ew[26:16]));
                    chk("wr_data", int'($signed(o_wr_data)), int'($signed(ew[15:0])));
                end
            end
            if (o_frame_ready) begin
                if (exp_fr_q.size() == 0) begin
                    chk("unexpected_frame", int'(o_rd_base), -1);
                end else begin
                    ef = exp_fr_q.pop_front();
                    chk("frame_bank", int'(o_rd_bank), int'(ef[10]));
                    chk("frame_base", int'(o_rd_base), int'(ef[9:0]));
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic signed [15:0] s, input logic vb, input logic arm);
        @(posedge clk);
        #1;
        i_sample_valid = v;
        i_sample       = s;
        i_vblank       = vb;
        i_arm          = arm;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 16'sd0, 1'b0, 1'b0);
    endtask

    task automatic send_tick(input logic signed [15:0] s, input bit wr);
        if (wr) begin
            exp_wr_q.push_back({exp_bank, 10'(exp_idx), s});
            exp_idx = (exp_idx == 559) ? 0 : exp_idx + 1;
        end
        cyc(1'b1, s, 1'b0, 1'b0);
    endtask

    task automatic publish(input int base);
        exp_fr_q.push_back({exp_bank, 10'(base)});
        exp_bank = ~exp_bank;
        exp_idx  = 0;
        cyc(1'b0, 16'sd0, 1'b1, 1'b0);
    endtask

    task automatic check_state(input string name, input int st, input int trig);
        @(negedge clk);
        chk({name, "_state"}, int'(o_state), st);
        chk({name, "_triggered"}, int'(o_triggered), trig);
    endtask

    function automatic logic signed [15:0] tri_wave(input int k);
        int p;
        p = k % 40;
        if (p < 20) return 16'(-1000 + 100 * p);
        return 16'(1000 - 100 * (p - 20));
    endfunction

    initial begin
        int wr0;
        i_rst = 1'b1; i_sample_valid = 1'b0; i_sample = '0; i_mode = 2'd0;
        i_slope = 1'b0; i_trig_level = '0; i_decim = 4'd0; i_arm = 1'b0; i_vblank = 1'b0;
        exp_bank = 1'b0; exp_idx = 0;
        idle(3);
        @(negedge clk);
        chk("rst_state", int'(o_state), 0);
        chk("rst_wr_en", int'(o_wr_en), 0);
        chk("rst_rd_bank", int'(o_rd_bank), 0);
        chk("rst_rd_base", int'(o_rd_base), 0);
        chk("rst_frame_ready", int'(o_frame_ready), 0);
        chk("rst_triggered", int'(o_triggered), 0);

        // 1: AUTO, rising through 0; trigger on tick 290 -> base 10, bank 0.
        @(posedge clk); #1; i_rst = 1'b0;
        idle(1);
        check_state("t1_start", 1, 0);
        for (int k = 0; k < 570; k++) begin
            if (k == 290) begin idle(1); check_state("t1_armed", 2, 0); end
            if (k == 291) begin idle(1); check_state("t1_post", 3, 1); end
            send_tick(tri_wave(k), 1'b1);
        end
        idle(1);
        check_state("t1_hold", 4, 1);
        repeat (3) send_tick(16'sd100, 1'b0);
        // Publish with a coincident tick that must land at bank 1 index 0.
        i_mode = 2'd1;
        exp_fr_q.push_back({exp_bank, 10'd10});
        exp_bank = 1'b1; exp_idx = 0;
        exp_wr_q.push_back({exp_bank, 10'd0, 16'sd100});
        exp_idx = 1;
        cyc(1'b1, 16'sd100, 1'b1, 1'b0);
        idle(1);
        check_state("t1_pub", 1, 0);
        chk("t1_rd_base", int'(o_rd_base), 10);
        chk("t1_trig_sample", int'(shadow[0][290]), 0);
        chk("t1_pre_sample", int'(shadow[0][289]), -100);

        // 2: NORMAL, constant 100 never crosses: writes keep going, no frame.
        for (int k = 1; k < 880; k++) send_tick(16'sd100, 1'b1);
        idle(1);
        check_state("t2_armed", 2, 0);
        cyc(1'b0, 16'sd0, 1'b1, 1'b0);
        idle(2);
        check_state("t2_still", 2, 0);

        // 3: reset mid-capture, then AUTO timeout forces trigger on ARMED tick 4096.
        @(posedge clk); #1; i_rst = 1'b1; i_mode = 2'd0;
        idle(2);
        @(negedge clk);
        chk("t3_rst_state", int'(o_state), 0);
        chk("t3_rst_rd_base", int'(o_rd_base), 0);
        chk("t3_rst_rd_bank", int'(o_rd_bank), 0);
        @(posedge clk); #1; i_rst = 1'b0;
        exp_bank = 1'b0; exp_idx = 0;
        idle(1);
        check_state("t3_start", 1, 0);
        for (int k = 0; k < 4655; k++) begin
            if (k == 4375) begin idle(1); check_state("t3_armed", 2, 0); end
            if (k == 4376) begin idle(1); check_state("t3_forced", 3, 1); end
            send_tick(16'sd100, 1'b1);
        end
        idle(1);
        check_state("t3_hold", 4, 1);
        i_mode = 2'd2;
        publish(175);
        idle(1);
        check_state("t3_single_idle", 0, 0);

        // 4/6: SINGLE idles without writes; i_arm captures into bank 1, trigger at index 100.
        repeat (5) send_tick(-16'sd100, 1'b0);
        idle(1);
        check_state("t4_idle", 0, 0);
        cyc(1'b0, 16'sd0, 1'b0, 1'b1);
        idle(1);
        check_state("t4_armed_pre", 1, 0);
        for (int k = 0; k < 940; k++) begin
            if (k == 660) begin idle(1); check_state("t4_armed", 2, 0); end
            send_tick((k < 660) ? -16'sd100 : 16'sd100, 1'b1);
        end
        cyc(1'b0, 16'sd0, 1'b1, 1'b0);
        idle(1);
        check_state("t6_entry_vblank", 4, 1);
        publish(380);
        idle(1);
        check_state("t4_done", 0, 0);
        chk("t6_rd_base", int'(o_rd_base), 380);
        chk("t4_rd_bank", int'(o_rd_bank), 1);

        // 5: decim 3 keeps every 4th pulse; falling trigger 50 -> -50 at index 281.
        i_decim = 4'd3; i_slope = 1'b1; i_mode = 2'd1;
        idle(1);
        check_state("t5_start", 1, 0);
        wr0 = n_wr;
        for (int t = 0; t < 561; t++) begin
            if (t == 3) begin idle(2); chk("t5_decim_wr_cnt", n_wr - wr0, 3); end
            if (t == 281) begin idle(1); check_state("t5_armed", 2, 0); end
            repeat (3) cyc(1'b1, -16'sd30000, 1'b0, 1'b0);
            send_tick((t <= 280) ? 16'sd50 : -16'sd50, 1'b1);
        end
        idle(1);
        check_state("t5_hold", 4, 1);
        publish(1);
        idle(1);
        check_state("t5_rearm", 1, 0);

        idle(4);
        chk("wr_queue_empty", exp_wr_q.size(), 0);
        chk("frame_queue_empty", exp_fr_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
